// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Oversampling UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined),
// with a valid/acknowledge holding register and frame/parity/overrun flags.
// Rev    : 1.0
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       dataReady,
  input  logic       readAck,
  output logic       frameError,
  output logic       parityError,
  output logic       overrun
);

  localparam int              c_CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic            r_rx_meta;
  logic            r_rx_s;
  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_commit_pend;
  logic            r_ferr_pend;
  logic [7:0]      r_rx_data;
  logic            r_data_ready;
  logic            r_frame_err;
  logic            r_overrun;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_perr_pend;
  logic            r_parity_err;
`endif

  logic w_expire;
  assign w_expire = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_commit_pend <= 1'b0;
      r_ferr_pend   <= 1'b0;
      r_rx_data     <= 8'h00;
      r_data_ready  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad     <= 1'b0;
      r_perr_pend   <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_rx_meta     <= rx;
      r_rx_s        <= r_rx_meta;
      r_commit_pend <= 1'b0;
      r_ferr_pend   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_pend   <= 1'b0;
`endif
      if (!w_expire) begin
        r_cnt <= r_cnt - c_ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= c_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt     <= c_FULL;
              r_bit_idx <= 3'd0;
              r_state   <= S_DATA;
`ifdef UART_RX_PARITY_EN
              r_par_bad <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (w_expire) begin
            r_shift[r_bit_idx] <= r_rx_s;
            r_cnt              <= c_FULL;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_expire) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            r_par_bad <= r_rx_s ^ (^r_shift);
            r_cnt     <= c_FULL;
            r_state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leave mid stop bit so a back-to-back start edge is not missed.
          if (w_expire) begin
            if (!r_rx_s) begin
              r_ferr_pend <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end else begin
`ifdef UART_RX_PARITY_EN
              r_perr_pend   <= r_par_bad;
              r_commit_pend <= !r_par_bad;
`else
              r_commit_pend <= 1'b1;
`endif
              r_state       <= S_IDLE;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Holding register: a commit overrides an acknowledge in the same cycle.
      if (r_commit_pend) begin
        r_rx_data    <= r_shift;
        r_data_ready <= 1'b1;
        r_overrun    <= (r_data_ready && readAck) ? 1'b0 : (r_overrun | r_data_ready);
      end else if (r_data_ready && readAck) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
      end
      r_frame_err <= r_ferr_pend;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= r_perr_pend;
`endif
    end
  end

  assign rxData     = r_rx_data;
  assign dataReady  = r_data_ready;
  assign frameError = r_frame_err;
  assign overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parityError = r_parity_err;
`else
  assign parityError = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx
// Randomized and directed frames against a frame-level reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P       = 1;
  localparam int LAT_LIT = 171;
`else
  localparam int P       = 0;
  localparam int LAT_LIT = 155;
`endif
  localparam int LAT = 2 + C / 2 + (9 + P) * C + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       readAck = 1'b0;
  logic [7:0] rxData;
  logic       dataReady;
  logic       frameError;
  logic       parityError;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rxData      (rxData),
    .dataReady   (dataReady),
    .readAck     (readAck),
    .frameError  (frameError),
    .parityError (parityError),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // kind: 0 = commit, 1 = frame error, 2 = parity error
  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  ev_t         evq[$];
  int unsigned cyc = 0;
  logic        m_ready = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_ferr  = 1'b0;
  logic        m_perr  = 1'b0;
  logic [7:0]  m_data  = 8'h00;
  int          n_vec   = 0;
  int          n_fail  = 0;
  int          ferr_count = 0;
  int          perr_count = 0;
  bit          ack_rand = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame outcomes are scheduled at the cycle the spec's latency implies.
  always @(posedge clk) begin : p_model
    ev_t e;
    bit  have;
    cyc++;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    have   = 1'b0;
    if (rst_n) begin
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
        e    = evq.pop_front();
        have = 1'b1;
      end
      if (have && e.kind == 1) m_ferr = 1'b1;
      if (have && e.kind == 2) m_perr = 1'b1;
      if (have && e.kind == 0) begin
        if (m_ready && readAck)  m_ovr = 1'b0;
        else if (m_ready)        m_ovr = 1'b1;
        m_data  = e.data;
        m_ready = 1'b1;
      end else if (readAck && m_ready) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    if (cyc >= 1) begin
      check("outputs", {4'h0, dataReady, overrun, frameError, parityError, rxData},
                       {4'h0, m_ready, m_ovr, m_ferr, m_perr, m_data});
      if (frameError === 1'b1)  ferr_count++;
      if (parityError === 1'b1) perr_count++;
    end
  end

  initial begin : p_ack_rand
    forever begin
      @(negedge clk);
      if (ack_rand) readAck = ($urandom_range(0, 7) == 0);
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Call at a negedge; the next rising edge is the first to sample the start bit.
  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
    ev_t e;
    e.cyc  = cyc + 1 + LAT;
    e.data = d;
    e.kind = stop_bad ? 1 : (par_bad ? 2 : 0);
    evq.push_back(e);
    drive_bit(1'b0, C);
    for (int i = 0; i < 8; i++) drive_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bad, C);
`endif
    drive_bit(!stop_bad, C);
  endtask

  task automatic wait_rise(input int budget, output int unsigned when);
    int k;
    k    = 0;
    when = 0;
    while (dataReady !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dataReady === 1'b1) begin
      when = cyc;
    end else begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_ready: dataReady=%b after %0d cycles, required 1", dataReady, budget);
    end
  endtask

  task automatic ack_pulse();
    readAck = 1'b1;
    @(negedge clk);
    readAck = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    evq.delete();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int unsigned n0;
    int unsigned rise;
    int          f0;
    int          p0;
    bit          prev_bad;
    bit          sb;
    bit          pb;

    apply_reset(3);
    check("reset_dataReady", 16'(dataReady), 16'h0);
    check("reset_rxData",    16'(rxData),    16'h0);
    check("reset_overrun",   16'(overrun),   16'h0);
    idle(5);

    // Single byte latency and acknowledge.
    n0 = cyc + 1;
    fork
      send_frame(8'hA5, 1'b0, 1'b0);
      wait_rise(LAT + 40, rise);
    join
    check("latency_A5", 16'(rise - n0), 16'(LAT_LIT));
    check("data_A5",    16'(rxData),     16'h00A5);
    ack_pulse();
    check("ack_clears", 16'(dataReady),  16'h0);
    idle(C);

    // Back-to-back frames without acknowledge.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    check("b2b_data",    16'(rxData),    16'h0081);
    check("b2b_ready",   16'(dataReady), 16'h1);
    check("b2b_overrun", 16'(overrun),   16'h1);
    ack_pulse();
    check("b2b_ack", 16'({dataReady, overrun}), 16'h0);
    idle(C);

    // Short glitch must be rejected as a false start.
    f0 = ferr_count;
    p0 = perr_count;
    drive_bit(1'b0, 4);
    idle(3 * C);
    check("glitch_ready", 16'(dataReady), 16'h0);
    check("glitch_flags", 16'((ferr_count - f0) + (perr_count - p0)), 16'h0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("after_glitch", 16'(rxData), 16'h005A);
    ack_pulse();
    idle(C);

    // Break: low stop bit then long low line.
    f0 = ferr_count;
    send_frame(8'h00, 1'b0, 1'b1);
    drive_bit(1'b0, 40 * C);
    idle(2 * C);
    check("break_ferr",  16'(ferr_count - f0), 16'h1);
    check("break_ready", 16'(dataReady),       16'h0);
    send_frame(8'h55, 1'b0, 1'b0);
    check("after_break", 16'({dataReady, rxData}), 16'h0155);
    ack_pulse();
    idle(C);

    // Reset during bit 4 of 0xF0.
    drive_bit(1'b0, C);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, C);
    drive_bit(1'b1, C / 2);
    apply_reset(4);
    check("midreset_ready", 16'({dataReady, overrun}), 16'h0);
    idle(C);
    send_frame(8'h0F, 1'b0, 1'b0);
    check("after_reset", 16'({dataReady, rxData}), 16'h010F);
    ack_pulse();
    idle(C);

`ifdef UART_RX_PARITY_EN
    p0 = perr_count;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(C);
    check("parity_bad_pulse", 16'(perr_count - p0), 16'h1);
    check("parity_bad_ready", 16'(dataReady),       16'h0);
    n0 = cyc + 1;
    fork
      send_frame(8'h07, 1'b0, 1'b0);
      wait_rise(LAT + 40, rise);
    join
    check("parity_ok_latency", 16'(rise - n0), 16'd171);
    check("parity_ok_data",    16'(rxData),     16'h0007);
    ack_pulse();
    idle(C);
`endif

    // Randomized frames with random acknowledges.
    ack_rand = 1'b1;
    prev_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      sb = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
      pb = ($urandom_range(0, 5) == 0);
`else
      pb = 1'b0;
`endif
      idle(prev_bad ? $urandom_range(2, 30) : $urandom_range(0, 30));
      send_frame(8'($urandom_range(0, 255)), pb, sb);
      prev_bad = sb;
    end
    idle(2 * C);
    ack_rand = 1'b0;
    readAck  = 1'b0;
    idle(2 * C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
